// File: rtl/auth_pkg.sv
// Shared types and sizing helpers for the Toeplitz-hash MAC engine.
//   state_e        : engine FSM states
//   kw_width()     : width of the Toeplitz key window {s_key, seed}
//   cnt_width()    : width of the per-message beat counter
package auth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Key window spans one beat of fresh key plus the carried-over seed bits.
  function automatic int unsigned kw_width(input int unsigned tag_w,
                                           input int unsigned data_w);
    return data_w + tag_w - 1;
  endfunction

  // Counter must hold 0 .. max_beats-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return (max_beats <= 1) ? 1 : $clog2(max_beats);
  endfunction

endpackage

// File: rtl/toeplitz_row_xor.sv
// One Toeplitz row: GF(2) inner product of a message beat with a key slice.
//   data      : message beat
//   key_slice : DATA_WIDTH-bit diagonal slice of the key window for this row
//   parity_c  : combinational parity of (data & key_slice)
module toeplitz_row_xor #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] key_slice,
  output logic                  parity_c
);

  assign parity_c = ^(data & key_slice);

endmodule

// File: rtl/toeplitz_mac_acc.sv
// Streaming GF(2) Toeplitz-hash MAC engine.
// Accumulates a TAG_WIDTH-bit tag over DATA_WIDTH-bit message beats, each
// paired with DATA_WIDTH fresh key bits; holds the finished tag until consumed.
// Optional feature macro: TOEPLITZ_OTP_EN (mask finished tag with otp).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, key_seed     : open a message (IDLE only) and load the initial key bits
//   s_valid/s_ready     : beat handshake; s_data, s_key, s_last carry the beat
//   otp                 : one-time pad, sampled on the finishing beat
//   tag/tag_valid       : finished tag, held until tag_ready
//   overrun             : message cut off at MAX_BEATS without s_last
module toeplitz_mac_acc import auth_pkg::*; #(
  parameter int unsigned TAG_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BEATS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TAG_WIDTH-2:0]  key_seed,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [DATA_WIDTH-1:0] s_key,
  input  logic                  s_last,
  input  logic [TAG_WIDTH-1:0]  otp,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic                  tag_valid,
  input  logic                  tag_ready,
  output logic                  overrun
);

  localparam int unsigned KW = kw_width(TAG_WIDTH, DATA_WIDTH);
  localparam int unsigned CW = cnt_width(MAX_BEATS);

  state_e                state_q;
  state_e                state_d;
  logic [TAG_WIDTH-2:0]  seed_r;
  logic [TAG_WIDTH-1:0]  acc;
  logic [CW-1:0]         cnt;

  logic [KW-1:0]         window_c;
  logic [TAG_WIDTH-1:0]  row_par_c;
  logic [TAG_WIDTH-1:0]  acc_next_c;
  logic [TAG_WIDTH-1:0]  tag_next_c;
  logic                  start_ok_c;
  logic                  accept_c;
  logic                  at_limit_c;
  logic                  finish_c;

  assign window_c   = {s_key, seed_r};
  assign acc_next_c = acc ^ row_par_c;
  assign start_ok_c = (state_q == IDLE) & start;
  assign accept_c   = s_valid & s_ready;
  assign at_limit_c = (cnt == CW'(MAX_BEATS - 1));
  assign finish_c   = accept_c & (s_last | at_limit_c);

  // Row i of the Toeplitz matrix sees the window shifted by i bits.
  for (genvar i = 0; i < TAG_WIDTH; i++) begin : g_row
    toeplitz_row_xor #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_row (
      .data      (s_data),
      .key_slice (window_c[i +: DATA_WIDTH]),
      .parity_c  (row_par_c[i])
    );
  end

`ifdef TOEPLITZ_OTP_EN
  // Wegman-Carter: encrypt the hash with the one-time pad.
  assign tag_next_c = acc_next_c ^ otp;
`else
  assign tag_next_c = acc_next_c;
  logic unused_otp_c;
  assign unused_otp_c = ^otp;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = ACCUM;
      ACCUM:   if (finish_c)  state_d = DONE;
      DONE:    if (tag_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_r    <= '0;
      acc       <= '0;
      cnt       <= '0;
      s_ready   <= 1'b0;
      tag       <= '0;
      tag_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Ready mirrors the ACCUM state without a combinational output path.
      s_ready <= (state_d == ACCUM);

      if (start_ok_c) begin
        seed_r <= key_seed;
        acc    <= '0;
        cnt    <= '0;
      end

      if (accept_c) begin
        acc    <= acc_next_c;
        // Top key bits of this window become the seed for the next beat.
        seed_r <= window_c[KW-1 -: TAG_WIDTH-1];
        cnt    <= cnt + CW'(1);
      end

      if (finish_c) begin
        tag       <= tag_next_c;
        tag_valid <= 1'b1;
        overrun   <= ~s_last;
      end else if ((state_q == DONE) && tag_ready) begin
        tag_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toeplitz_mac_acc.sv
// Self-checking bench for toeplitz_mac_acc (TAG_WIDTH=4, DATA_WIDTH=8, MAX_BEATS=4).
// Reference: tag[i] = XOR over message bits j of msg[j] & stream[j+i], where
// stream is the seed bits followed by every beat's key bits in arrival order.
module tb_toeplitz_mac_acc;

  localparam int TW = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [TW-2:0] key_seed;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [DW-1:0] s_key;
  logic          s_last;
  logic [TW-1:0] otp;
  logic [TW-1:0] tag;
  logic          tag_valid;
  logic          tag_ready;
  logic          overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] msg_d [0:MB];
  logic [DW-1:0] msg_k [0:MB];

  always #5 clk = ~clk;

  toeplitz_mac_acc #(
    .TAG_WIDTH (TW),
    .DATA_WIDTH(DW),
    .MAX_BEATS (MB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_seed (key_seed),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_key    (s_key),
    .s_last   (s_last),
    .otp      (otp),
    .tag      (tag),
    .tag_valid(tag_valid),
    .tag_ready(tag_ready),
    .overrun  (overrun)
  );

  function automatic logic [TW-1:0] model_tag(input logic [TW-2:0] seed, input int nb);
    logic          stream [0:TW-2+DW*(MB+1)];
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW - 1; i++) stream[i] = seed[i];
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < DW; k++) stream[TW-1+b*DW+k] = msg_k[b][k];
    for (int i = 0; i < TW; i++)
      for (int j = 0; j < nb * DW; j++)
        t[i] = t[i] ^ (msg_d[j/DW][j%DW] & stream[j+i]);
    return t;
  endfunction

  function automatic logic [TW-1:0] expect_tag(input logic [TW-2:0] seed, input int nb,
                                               input logic [TW-1:0] pad);
`ifdef TOEPLITZ_OTP_EN
    return model_tag(seed, nb) ^ pad;
`else
    return model_tag(seed, nb) ^ (pad & '0);
`endif
  endfunction

  // Stimulus helpers: called and returned at a falling edge.
  task automatic start_msg(input logic [TW-2:0] seed);
    start = 1'b1;
    key_seed = seed;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [DW-1:0] k,
                           input logic last, input int budget, output bit ok);
    s_valid = 1'b1; s_data = d; s_key = k; s_last = last; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic consume();
    tag_ready = 1'b1;
    @(negedge clk);
    tag_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({tag, tag_valid, overrun, s_ready} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got tag=%h tv=%b ov=%b rdy=%b, expected all zero",
               tag, tag_valid, overrun, s_ready);
    end
    // Beats without start must never be taken.
    s_valid = 1'b1; s_last = 1'b1; s_data = 8'hFF; s_key = 8'hFF;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b0 || tag_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL no_start_beat: got rdy=%b tv=%b, expected 0 0", s_ready, tag_valid);
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_vectors();
    bit ok;
    // seed=000, data=01, key=01: stream bit 3 is the only key one -> tag bit 3.
    start_msg(3'b000);
    send_beat(8'h01, 8'h01, 1'b1, 4, ok);
    n_checks++;
    if (!ok || tag_valid !== 1'b1 || tag !== 4'b1000) begin
      n_errors++;
      $display("FAIL vector_zero_seed: got ok=%b tv=%b tag=%b, expected 1 1 1000", ok, tag_valid, tag);
    end
    consume();
    // seed=111, data=01, key=00: rows 0..2 hit a seed one -> 0111, one-cycle latency.
    start_msg(3'b111);
    s_valid = 1'b1; s_data = 8'h01; s_key = 8'h00; s_last = 1'b1;
    n_checks++;
    if (s_ready !== 1'b1 || tag_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL vector_pre_accept: got rdy=%b tv=%b, expected 1 0", s_ready, tag_valid);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++;
    if (tag_valid !== 1'b1 || tag !== 4'b0111 || overrun !== 1'b0) begin
      n_errors++;
      $display("FAIL vector_ones_seed: got tv=%b tag=%b ov=%b, expected 1 0111 0", tag_valid, tag, overrun);
    end
    consume();
  endtask

  task automatic test_random();
    bit ok;
    logic [TW-2:0] seed;
    logic [TW-1:0] exp_t;
    int nb;
    for (int m = 0; m < 1000; m++) begin
      seed = (TW-1)'($urandom());
      nb   = $urandom_range(1, MB);
      otp  = (m % 5 == 0) ? '1 : TW'($urandom());
      start_msg(seed);
      for (int b = 0; b < nb; b++) begin
        msg_d[b] = DW'($urandom());
        msg_k[b] = DW'($urandom());
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(msg_d[b], msg_k[b], (b == nb - 1), 4, ok);
        if (!ok) begin
          n_errors++;
          $display("FAIL random_beat_timeout: msg %0d beat %0d not accepted", m, b);
        end
      end
      exp_t = expect_tag(seed, nb, otp);
      n_checks++;
      if (tag_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL random_tag_valid: msg %0d got %b expected 1", m, tag_valid);
      end
      n_checks++;
      if (tag !== exp_t) begin
        n_errors++;
        $display("FAIL random_tag: msg %0d nb %0d got %h expected %h", m, nb, tag, exp_t);
      end
      n_checks++;
      if (overrun !== 1'b0) begin
        n_errors++;
        $display("FAIL random_overrun: msg %0d got %b expected 0", m, overrun);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      consume();
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [TW-2:0] seed;
    logic [TW-1:0] exp_t;
    seed = 3'b101;
    otp  = 4'h0;
    start_msg(seed);
    for (int b = 0; b < MB; b++) begin
      msg_d[b] = DW'($urandom());
      msg_k[b] = DW'($urandom());
      send_beat(msg_d[b], msg_k[b], 1'b0, 4, ok);
      n_checks++;
      if (!ok) begin
        n_errors++;
        $display("FAIL overrun_beat_accept: beat %0d got ok=0 expected 1", b);
      end
    end
    exp_t = model_tag(seed, MB);
    n_checks++;
    if (tag_valid !== 1'b1 || overrun !== 1'b1 || tag !== exp_t) begin
      n_errors++;
      $display("FAIL overrun_tag: got tv=%b ov=%b tag=%h, expected 1 1 %h", tag_valid, overrun, tag, exp_t);
    end
    // Fifth beat must be refused while the tag waits.
    s_valid = 1'b1; s_data = 8'hA5; s_key = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (s_ready !== 1'b0 || tag !== exp_t || overrun !== 1'b1) begin
        n_errors++;
        $display("FAIL overrun_fifth_beat: got rdy=%b tag=%h ov=%b, expected 0 %h 1", s_ready, tag, overrun, exp_t);
      end
    end
    s_valid = 1'b0;
    consume();
  endtask

  task automatic test_hold();
    bit ok;
    logic [TW-2:0] seed;
    logic [TW-1:0] exp_t;
    seed = 3'b011;
    otp  = 4'hF;
    start_msg(seed);
    for (int b = 0; b < 2; b++) begin
      msg_d[b] = DW'($urandom());
      msg_k[b] = DW'($urandom());
      send_beat(msg_d[b], msg_k[b], (b == 1), 4, ok);
    end
    exp_t = expect_tag(seed, 2, 4'hF);
    s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      start    = 1'($urandom());
      key_seed = (TW-1)'($urandom());
      otp      = TW'($urandom());
      @(negedge clk);
      n_checks++;
      if (tag !== exp_t || tag_valid !== 1'b1 || s_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_stable: cycle %0d got tag=%h tv=%b rdy=%b, expected %h 1 0", c, tag, tag_valid, s_ready, exp_t);
      end
    end
    // Start in the consuming cycle is dropped.
    s_valid = 1'b0;
    start = 1'b1; tag_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; tag_ready = 1'b0;
    n_checks++;
    if (tag_valid !== 1'b0 || s_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL consume_with_start: got tv=%b rdy=%b, expected 0 0", tag_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [TW-2:0] seed;
    logic [TW-1:0] exp_t;
    start_msg(3'b110);
    for (int b = 0; b < 2; b++) begin
      send_beat(DW'($urandom()), DW'($urandom()), 1'b0, 4, ok);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tag, tag_valid, overrun, s_ready} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got tag=%h tv=%b ov=%b rdy=%b, expected all zero",
               tag, tag_valid, overrun, s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    seed = 3'b010;
    otp  = 4'h3;
    start_msg(seed);
    for (int b = 0; b < 3; b++) begin
      msg_d[b] = DW'($urandom());
      msg_k[b] = DW'($urandom());
      send_beat(msg_d[b], msg_k[b], (b == 2), 4, ok);
    end
    exp_t = expect_tag(seed, 3, 4'h3);
    n_checks++;
    if (tag_valid !== 1'b1 || tag !== exp_t) begin
      n_errors++;
      $display("FAIL reset_mid_new_msg: got tv=%b tag=%h, expected 1 %h", tag_valid, tag, exp_t);
    end
    consume();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_seed = '0; s_valid = 1'b0;
    s_data = '0; s_key = '0; s_last = 1'b0; otp = '0; tag_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_overrun();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
